// File: rtl/alu_op_sequencer_if.sv
// Handshake and status bundle between the execute-button sequencer and its
// surroundings (button/switch inputs, multi-cycle unit, register strobes).
interface alu_op_sequencer_if;
  logic       btn_execute;
  logic [3:0] operation;
  logic       op_done;
  logic       enable_A;
  logic       enable_B;
  logic       enable_Y;
  logic       op_start;
  logic [3:0] op_sel;
  logic       busy;
  logic       err;
  logic [2:0] state;

  modport master (
    output btn_execute, operation, op_done,
    input  enable_A, enable_B, enable_Y, op_start, op_sel, busy, err, state
  );

  modport slave (
    input  btn_execute, operation, op_done,
    output enable_A, enable_B, enable_Y, op_start, op_sel, busy, err, state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps the 8-bit ALU datapath (load A, load B, issue, show) on each
// debounced press of the execute button; multi-cycle ops use op_start/op_done.
module alu_op_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         TIMEOUT_CYCLES  = 16,
  parameter int         NUM_OPS         = 8,
  parameter logic [7:0] MULTI_MASK      = 8'b1100_0000
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;

  localparam int             DBW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int             TOW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST      = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST      = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]    MULTI_MASK_X = 16'(MULTI_MASK);

  logic           r_sync1, r_sync2, r_db, r_db_d;
  logic [DBW-1:0] r_db_cnt;
  logic           w_press;

  logic [2:0]     r_state, w_state_nxt;
  logic [TOW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic           r_en_a, r_en_b, r_en_y, r_op_start, r_busy, r_err;
  logic           w_en_a_nxt, w_en_b_nxt, w_en_y_nxt, w_op_start_nxt, w_busy_nxt, w_err_nxt;
  logic [3:0]     r_op_sel, w_op_sel_nxt;
  logic           w_op_valid, w_op_multi, w_to_last;

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= bus.btn_execute;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press    = r_db & ~r_db_d;
  assign w_op_valid = ({28'd0, bus.operation} < 32'(NUM_OPS));
  assign w_op_multi = MULTI_MASK_X[bus.operation];
  assign w_to_last  = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_LOAD_A;
      r_to_cnt   <= '0;
      r_en_a     <= 1'b0;
      r_en_b     <= 1'b0;
      r_en_y     <= 1'b0;
      r_op_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_op_sel   <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_en_a     <= w_en_a_nxt;
      r_en_b     <= w_en_b_nxt;
      r_en_y     <= w_en_y_nxt;
      r_op_start <= w_op_start_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_op_sel   <= w_op_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD_A: if (w_press) w_state_nxt = S_LOAD_B;
      S_LOAD_B: if (w_press) w_state_nxt = S_READY;
      S_READY:  if (w_press && w_op_valid) w_state_nxt = w_op_multi ? S_WAIT : S_SHOW;
      S_WAIT:   if (bus.op_done || w_to_last) w_state_nxt = S_SHOW;
      S_SHOW:   if (w_press) w_state_nxt = S_LOAD_A;
      default:  w_state_nxt = S_LOAD_A;
    endcase
  end

  // Next values of the registered outputs; op_done beats the timeout in the same cycle.
  always_comb begin
    w_en_a_nxt     = 1'b0;
    w_en_b_nxt     = 1'b0;
    w_en_y_nxt     = 1'b0;
    w_op_start_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    w_op_sel_nxt   = r_op_sel;
    w_to_cnt_nxt   = r_to_cnt;
    case (r_state)
      S_LOAD_A: begin
        if (w_press) begin
          w_en_a_nxt = 1'b1;
          w_err_nxt  = 1'b0;
        end
      end
      S_LOAD_B: begin
        if (w_press) w_en_b_nxt = 1'b1;
      end
      S_READY: begin
        if (w_press) begin
          if (!w_op_valid) begin
            w_err_nxt = 1'b1;
          end else begin
            w_op_sel_nxt = bus.operation;
            w_err_nxt    = 1'b0;
            if (w_op_multi) begin
              w_op_start_nxt = 1'b1;
              w_busy_nxt     = 1'b1;
              w_to_cnt_nxt   = '0;
            end else begin
              w_en_y_nxt = 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        w_to_cnt_nxt = r_to_cnt + 1'b1;
        if (bus.op_done) begin
          w_en_y_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end else if (w_to_last) begin
          w_err_nxt  = 1'b1;
          w_busy_nxt = 1'b0;
        end
      end
      S_SHOW: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.enable_A = r_en_a;
  assign bus.enable_B = r_en_b;
  assign bus.enable_Y = r_en_y;
  assign bus.op_start = r_op_start;
  assign bus.op_sel   = r_op_sel;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized
// operation sequences predicted by a step-level model of the button sequencer.
module tb_alu_op_sequencer;
  localparam int         D    = 4;
  localparam int         TO   = 16;
  localparam int         NOPS = 8;
  localparam logic [7:0] MM   = 8'b1100_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (TO),
    .NUM_OPS        (NOPS),
    .MULTI_MASK     (MM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-scenario tallies of cycles each output was high, sampled after the edge.
  int c_a, c_b, c_y, c_s, c_busy, c_multi;
  always @(posedge clk) begin
    #1;
    c_a    += int'(bus.enable_A);
    c_b    += int'(bus.enable_B);
    c_y    += int'(bus.enable_Y);
    c_s    += int'(bus.op_start);
    c_busy += int'(bus.busy);
    if ((int'(bus.enable_A) + int'(bus.enable_B) + int'(bus.enable_Y) + int'(bus.op_start)) > 1)
      c_multi++;
  end

  // Model: which step the sequencer is on (0 load A, 1 load B, 2 ready, 4 show).
  int         m_state;
  logic       m_err;
  logic [3:0] m_op_sel;

  task automatic clr_counts();
    c_a = 0; c_b = 0; c_y = 0; c_s = 0; c_busy = 0; c_multi = 0;
  endtask

  // Returns #1 after the edge where the press-caused strobe should be visible.
  task automatic press_hold();
    @(negedge clk);
    bus.btn_execute = 1'b1;
    repeat (D + 3) @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    bus.btn_execute = 1'b0;
    repeat (D + 5) @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [3:0] op, input int d, input bit inject);
    int e_a, e_b, e_y, e_s, e_busy, nxt;
    bit multi;
    logic [3:0] now_exp, now_got;
    logic [15:0] mm;
    mm = 16'(MM);
    e_a = 0; e_b = 0; e_y = 0; e_s = 0; e_busy = 0; multi = 0;
    nxt = m_state;
    bus.operation = op;
    case (m_state)
      0: begin e_a = 1; m_err = 1'b0; nxt = 1; end
      1: begin e_b = 1; nxt = 2; end
      2: begin
        if (int'(op) >= NOPS) begin
          m_err = 1'b1;
        end else begin
          m_op_sel = op;
          m_err = 1'b0;
          nxt = 4;
          if (mm[op]) begin
            multi = 1;
            e_s = 1;
            if (d < TO) begin
              e_y = 1;
              e_busy = d + 1;
            end else begin
              e_busy = TO;
              m_err = 1'b1;
            end
          end else begin
            e_y = 1;
          end
        end
      end
      default: nxt = 0;
    endcase
    now_exp = {e_a != 0, e_b != 0, (e_y != 0) && !multi, e_s != 0};
    clr_counts();
    press_hold();
    now_got = {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start};
    checks++;
    if (now_got !== now_exp) begin
      errors++;
      $display("FAIL strobe_latency step=%0d got=%b exp=%b", m_state, now_got, now_exp);
    end
    if (multi) begin
      if (inject) begin
        bus.btn_execute = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
        bus.btn_execute = 1'b1;
        repeat (TO) @(posedge clk);
        #1;
      end else if (d < TO) begin
        repeat (d) @(posedge clk);
        #1;
        bus.op_done = 1'b1;
        @(posedge clk);
        #1;
        bus.op_done = 1'b0;
      end
      repeat (TO + 4) @(posedge clk);
      #1;
      bus.op_done = 1'b1;
      @(posedge clk);
      #1;
      bus.op_done = 1'b0;
    end
    release_btn();
    m_state = nxt;
    checks++;
    if (c_a !== e_a) begin errors++; $display("FAIL enable_A_cycles op=%0d got=%0d exp=%0d", op, c_a, e_a); end
    checks++;
    if (c_b !== e_b) begin errors++; $display("FAIL enable_B_cycles op=%0d got=%0d exp=%0d", op, c_b, e_b); end
    checks++;
    if (c_y !== e_y) begin errors++; $display("FAIL enable_Y_cycles op=%0d d=%0d got=%0d exp=%0d", op, d, c_y, e_y); end
    checks++;
    if (c_s !== e_s) begin errors++; $display("FAIL op_start_cycles op=%0d got=%0d exp=%0d", op, c_s, e_s); end
    checks++;
    if (c_busy !== e_busy) begin errors++; $display("FAIL busy_cycles op=%0d d=%0d got=%0d exp=%0d", op, d, c_busy, e_busy); end
    checks++;
    if (c_multi !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", c_multi); end
    checks++;
    if (bus.state !== 3'(m_state)) begin errors++; $display("FAIL state got=%0d exp=%0d", bus.state, m_state); end
    checks++;
    if (bus.err !== m_err) begin errors++; $display("FAIL err op=%0d got=%0d exp=%0d", op, bus.err, m_err); end
    checks++;
    if (bus.op_sel !== m_op_sel) begin errors++; $display("FAIL op_sel got=%0d exp=%0d", bus.op_sel, m_op_sel); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%0d exp=0", bus.busy); end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    bus.btn_execute = 1'b0;
    bus.operation = 4'd0;
    bus.op_done = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.err, bus.op_sel, bus.state};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.err, bus.op_sel, bus.state};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL post_reset_outputs got=%h exp=0", got); end
    m_state = 0; m_err = 1'b0; m_op_sel = 4'd0;
  endtask

  task automatic test_basic();
    do_step(4'd1, 0, 0);
    do_step(4'd1, 0, 0);
    do_step(4'd1, 0, 0);
    do_step(4'd1, 0, 0);
  endtask

  task automatic test_bounce();
    int pat_hi [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
    int pat_lo [6] = '{0, 1, 0, 0, 1, 0};
    int first;
    clr_counts();
    foreach (pat_hi[i]) begin
      @(negedge clk);
      bus.btn_execute = pat_hi[i][0];
    end
    @(negedge clk);
    bus.btn_execute = 1'b1;
    first = 0;
    for (int i = 1; i <= D + 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.enable_A === 1'b1 && first == 0) first = i;
    end
    checks++;
    if (first !== D + 3) begin errors++; $display("FAIL bounce_latency got=%0d exp=%0d", first, D + 3); end
    foreach (pat_lo[i]) begin
      @(negedge clk);
      bus.btn_execute = pat_lo[i][0];
    end
    @(negedge clk);
    bus.btn_execute = 1'b0;
    repeat (D + 6) @(posedge clk);
    #1;
    checks++;
    if (c_a !== 1) begin errors++; $display("FAIL bounce_enable_A_cycles got=%0d exp=1", c_a); end
    checks++;
    if ((c_b + c_y + c_s) !== 0) begin errors++; $display("FAIL bounce_other_strobes got=%0d exp=0", c_b + c_y + c_s); end
    checks++;
    if (bus.state !== 3'd1) begin errors++; $display("FAIL bounce_state got=%0d exp=1", bus.state); end
    m_state = 1; m_err = 1'b0;
    do_step(4'd0, 0, 0);
    do_step(4'd0, 0, 0);
    do_step(4'd0, 0, 0);
  endtask

  task automatic test_invalid_op();
    do_step(4'd3, 0, 0);
    do_step(4'd5, 0, 0);
    do_step(4'd9, 0, 0);
    do_step(4'd15, 0, 0);
    do_step(4'd2, 0, 0);
    do_step(4'd11, 0, 0);
  endtask

  task automatic test_multi_done();
    do_step(4'd4, 0, 0);
    do_step(4'd4, 0, 0);
    do_step(4'd6, 4, 0);
    do_step(4'd6, 0, 0);
    do_step(4'd4, 0, 0);
    do_step(4'd4, 0, 0);
    do_step(4'd7, TO - 1, 0);
    do_step(4'd7, 0, 0);
  endtask

  task automatic test_timeout();
    do_step(4'd0, 0, 0);
    do_step(4'd0, 0, 0);
    do_step(4'd7, TO + 4, 1);
    do_step(4'd1, 0, 0);
    do_step(4'd1, 0, 0);
  endtask

  task automatic test_reset_wait();
    logic [12:0] got;
    do_step(4'd6, 0, 0);
    bus.operation = 4'd6;
    clr_counts();
    press_hold();
    bus.btn_execute = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    got = {bus.enable_A, bus.enable_B, bus.enable_Y, bus.op_start, bus.busy, bus.err, bus.op_sel, bus.state};
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL async_reset_outputs got=%h exp=0", got); end
    bus.op_done = 1'b1;
    @(posedge clk);
    #1;
    bus.op_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (c_y !== 0) begin errors++; $display("FAIL reset_wait_enable_Y got=%0d exp=0", c_y); end
    checks++;
    if (c_s !== 1) begin errors++; $display("FAIL reset_wait_op_start got=%0d exp=1", c_s); end
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_wait_state got=%0d exp=0", bus.state); end
    m_state = 0; m_err = 1'b0; m_op_sel = 4'd0;
  endtask

  task automatic test_random();
    logic [3:0] op;
    int d, tries;
    bit inj;
    for (int it = 0; it < 30; it++) begin
      do_step(4'($urandom_range(0, 15)), 0, 0);
      do_step(4'($urandom_range(0, 15)), 0, 0);
      tries = 0;
      while (m_state == 2 && tries < 4) begin
        op = (tries == 3) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
        d = $urandom_range(0, TO + 3);
        inj = (d >= TO) && ($urandom_range(0, 1) == 1);
        do_step(op, d, inj);
        tries++;
      end
      do_step(4'($urandom_range(0, 15)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_invalid_op();
    test_multi_done();
    test_timeout();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the 8-bit ALU datapath from a single execute button.
- Each debounced press advances one step: load A, load B, issue the operation, then hold the result on the display.
- Single-cycle operations write Y directly. Multi-cycle operation units are started with op_start, and the block waits for op_done, with a timeout.
- Runs on the divided clock and drives the enable_A/enable_B/enable_Y strobes of the A, B and Y registers.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced button level changes.
- TIMEOUT_CYCLES, 16: S_WAIT cycles allowed for op_done before aborting.
- NUM_OPS, 8: opcodes >= NUM_OPS are invalid.
- MULTI_MASK, 8'b1100_0000: bit k set means opcode k is multi-cycle and uses the op_start/op_done handshake.

Ports:
- clk  input  1  divided system clock
- reset  input  1  asynchronous, active-high reset
- btn_execute  input  1  raw execute button, asynchronous to clk
- operation  input  4  opcode from sw[3:0]
- op_done  input  1  completion pulse from a multi-cycle unit
- enable_A  output  1  one-cycle load strobe, register A
- enable_B  output  1  one-cycle load strobe, register B
- enable_Y  output  1  one-cycle load strobe, register Y
- op_start  output  1  one-cycle start pulse to a multi-cycle unit
- op_sel  output  4  opcode latched at issue; drives the result mux and display decoder
- busy  output  1  high while in S_WAIT
- err  output  1  sticky error: invalid opcode or timeout
- state  output  3  current state code, for debug LEDs

Behaviour:
- Reset (asynchronous, active-high):
  - state = S_LOAD_A; all strobes 0; op_sel = 0; busy = 0; err = 0.
  - Sync flops, debounced level, debounce counter and timeout counter cleared.
  - Reset mid-operation (including in S_WAIT) abandons the operation; no strobe fires.
- Input conditioning:
  - btn_execute passes through a 2-flop synchronizer.
  - The debounced level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreement resets the counter.
  - press = one-cycle pulse on a 0->1 transition of the debounced level. Releases generate nothing.
- Output registration:
  - All outputs are registered.
  - A strobe caused by press in cycle N is high in cycle N+1 only.
  - At most one of enable_A, enable_B, enable_Y, op_start is high in any cycle.
- States and codes: S_LOAD_A=0, S_LOAD_B=1, S_READY=2, S_WAIT=3, S_SHOW=4. Unused codes recover to S_LOAD_A next cycle.
- S_LOAD_A: press -> enable_A pulse, clear err, go to S_LOAD_B.
- S_LOAD_B: press -> enable_B pulse, go to S_READY.
- S_READY, on press, operation is sampled in the press cycle:
  - operation >= NUM_OPS: err = 1, op_sel unchanged, stay in S_READY. The user may correct the switches and press again.
  - Valid single-cycle opcode: op_sel = operation, enable_Y pulse, err = 0, go to S_SHOW.
  - Valid multi-cycle opcode (MULTI_MASK[operation] = 1): op_sel = operation, op_start pulse, timeout counter = 0, busy = 1, err = 0, go to S_WAIT.
- S_WAIT:
  - Timeout counter increments every cycle.
  - op_done = 1 -> enable_Y pulse next cycle, busy = 0, go to S_SHOW.
  - Counter reaches TIMEOUT_CYCLES with op_done still 0 -> err = 1, busy = 0, no enable_Y, go to S_SHOW.
  - op_done arriving in the same cycle the counter reaches TIMEOUT_CYCLES -> op_done wins.
  - Presses in S_WAIT are discarded, not queued.
- S_SHOW: op_sel and Y are held. press -> go to S_LOAD_A with no strobe; err is preserved until the next S_LOAD_A press.
- op_done outside S_WAIT is ignored.
- operation changes outside the S_READY press cycle have no effect on op_sel.

Test Plan:
- Reset, then three clean presses with operation=4'd1 -> enable_A, enable_B, enable_Y each high exactly one cycle, in order; op_sel=1; state ends at 4.
- Button bounce of 1-2 cycle glitches during press 1 -> exactly one enable_A pulse; press asserted DEBOUNCE_CYCLES+2 cycles after input settles high.
- S_READY with operation=4'd9 -> err=1, no enable_Y/op_start, state stays 2. Then operation=4'd2 and press -> enable_Y pulse, err=0, op_sel=2.
- operation=4'd6 (multi-cycle), op_done returned 5 cycles after op_start, presses injected meanwhile -> op_start once, busy high 5 cycles, single enable_Y one cycle after op_done, presses ignored.
- operation=4'd7 with op_done held 0 -> after 16 cycles in S_WAIT, err=1, busy=0, no enable_Y, state=4.
- reset asserted asynchronously mid-S_WAIT, with op_done then pulsed -> all outputs 0 immediately, state=0, op_done ignored, no enable_Y.
